// File: rtl/fns_cac_decoder_multi_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fns_cac_decoder_multi_if : code-in / data-out handshake bundle of the FNS decoder
// Rev 1.0
// ----------------------------------------------------------------------------
interface fns_cac_decoder_multi_if #(
  parameter int NUM_GROUPS = 4,
  parameter int CODE_W     = 5,
  parameter int DATA_W     = 4,
  parameter int CNT_W      = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_GROUPS*CODE_W-1:0] codein;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_GROUPS*DATA_W-1:0] dataout;
  logic [NUM_GROUPS-1:0]        out_err;
  logic [CNT_W-1:0]             err_cnt;
  logic                         err_cnt_clr;

  modport master (
    output in_valid, codein, out_ready, err_cnt_clr,
    input  in_ready, out_valid, dataout, out_err, err_cnt
  );

  modport slave (
    input  in_valid, codein, out_ready, err_cnt_clr,
    output in_ready, out_valid, dataout, out_err, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fns_cac_decoder_multi.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fns_cac_decoder_multi : 2-stage pipelined multi-group Fibonacci (FNS) CAC decoder
// Rev 1.0
// ----------------------------------------------------------------------------
module fns_cac_decoder_multi #(
  parameter int NUM_GROUPS = 4,
  parameter int CODE_W     = 5,
  parameter int DATA_W     = 4,
  parameter int CNT_W      = 8
) (
  input  logic                    clock,
  input  logic                    rst_n,
  fns_cac_decoder_multi_if.slave  bus
);

  function automatic int fib_weight(input int k);
    int a, b, t;
    a = 1;
    b = 2;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int total_weight(input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) s = s + fib_weight(i);
    return s;
  endfunction

  // Sum width covers the all-ones codeword, so the range check sees every overflow.
  localparam int          SUM_W    = $clog2(total_weight(CODE_W) + 1);
  localparam logic [31:0] DATA_MAX = (32'd1 << DATA_W) - 32'd1;
  localparam int          PC_W     = $clog2(NUM_GROUPS + 1);
  localparam int          ACC_W    = CNT_W + PC_W;

  logic                         s1_valid_q, s1_valid_d;
  logic [SUM_W-1:0]             sum_d [NUM_GROUPS];
  logic [SUM_W-1:0]             sum_q [NUM_GROUPS];
  logic                         out_valid_q, out_valid_d;
  logic [NUM_GROUPS*DATA_W-1:0] data_d, data_q;
  logic [NUM_GROUPS-1:0]        err_d, err_q;
  logic [CNT_W-1:0]             err_cnt_q, err_cnt_d;
  logic                         s1_load, s2_load, in_ready;
  logic [PC_W-1:0]              err_pop;
  logic [ACC_W-1:0]             cnt_acc;
  logic [31:0]                  sum_ext;

  assign s2_load  = s1_valid_q & (~out_valid_q | bus.out_ready);
  assign in_ready = ~s1_valid_q | s2_load;
  assign s1_load  = bus.in_valid & in_ready;

  always_comb begin
    for (int g = 0; g < NUM_GROUPS; g++) begin
      sum_d[g] = '0;
      for (int k = 0; k < CODE_W; k++) begin
        if (bus.codein[g*CODE_W + k]) sum_d[g] = sum_d[g] + SUM_W'(fib_weight(k));
      end
    end
  end

  always_comb begin
    data_d  = '0;
    err_d   = '0;
    sum_ext = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      sum_ext  = 32'(sum_q[g]);
      err_d[g] = (sum_ext > DATA_MAX);
      data_d[g*DATA_W +: DATA_W] = err_d[g] ? {DATA_W{1'b1}} : sum_ext[DATA_W-1:0];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_load)      s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;

    out_valid_d = out_valid_q;
    if (s2_load)            out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;
  end

  // Clear takes priority; the increment saturates instead of wrapping.
  always_comb begin
    err_pop = '0;
    for (int g = 0; g < NUM_GROUPS; g++) err_pop = err_pop + PC_W'(err_q[g]);
    cnt_acc   = ACC_W'(err_cnt_q) + ACC_W'(err_pop);
    err_cnt_d = err_cnt_q;
    if (bus.err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (out_valid_q && bus.out_ready) begin
      if (cnt_acc > ACC_W'({CNT_W{1'b1}})) err_cnt_d = {CNT_W{1'b1}};
      else                                  err_cnt_d = cnt_acc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      err_q       <= '0;
      err_cnt_q   <= '0;
      for (int g = 0; g < NUM_GROUPS; g++) sum_q[g] <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      err_cnt_q   <= err_cnt_d;
      if (s1_load) begin
        for (int g = 0; g < NUM_GROUPS; g++) sum_q[g] <= sum_d[g];
      end
      if (s2_load) begin
        data_q <= data_d;
        err_q  <= err_d;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.dataout   = data_q;
  assign bus.out_err   = err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule
`default_nettype wire
